// File: rtl/ccip_c1_wr_issue_buf.sv
// Buffers AFU C1 write requests and issues them to CCI-P Tx C1 in FIFO order.
// Latency: 1 cycle from FIFO head to registered tx_valid; 2 cycles minimum from accepted request to tx_valid.
// Backpressure: req_ready drops when the FIFO is full; issue stalls on c1TxAlmFull or when the outstanding-write limit is reached.
module ccip_c1_wr_issue_buf #(
  parameter int HDR_W     = 80,
  parameter int DATA_W    = 512,
  parameter int DEPTH     = 16,
  parameter int MAX_OUTST = 64
) (
  input  logic                     pClk,
  input  logic                     SoftReset_n,
  input  logic                     req_valid,
  input  logic [HDR_W-1:0]         req_hdr,
  input  logic [DATA_W-1:0]        req_data,
  output logic                     req_ready,
  input  logic                     c1TxAlmFull,
  output logic                     tx_valid,
  output logic [HDR_W-1:0]         tx_hdr,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     rsp_valid,
  input  logic [2:0]               rsp_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [9:0]               outst_cnt,
  output logic                     err_rsp_unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = HDR_W + DATA_W;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [10:0]   MAX_L   = 11'(MAX_OUTST);

  // Storage is not reset: occupancy is tracked by level_q alone.
  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              tx_valid_q, tx_valid_d;
  logic [HDR_W-1:0]  tx_hdr_q, tx_hdr_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [9:0]        outst_q, outst_d;
  logic              err_q, err_d;
  logic              run_q;

  logic              push;
  logic              issue;
  logic              empty;
  logic [10:0]       outst_sum;
  logic [10:0]       rsp_dec;

  // Ready is held low while in reset so every output reads 0 there.
  assign req_ready = run_q & (level_q < DEPTH_L);
  assign push      = req_valid & req_ready;
  assign empty     = (level_q == '0);

  // outst_sum includes the request currently on tx_valid, which outst_q has not yet counted.
  assign outst_sum = {1'b0, outst_q} + {10'b0, tx_valid_q};
  assign rsp_dec   = rsp_valid ? {8'b0, rsp_cnt} : 11'd0;
  assign issue     = !empty && !c1TxAlmFull && (outst_sum < MAX_L);

  // Next-state for pointers, level, Tx register and outstanding tracking.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(issue);
    tx_valid_d = issue;
    tx_hdr_d   = '0;
    tx_data_d  = '0;
    outst_d    = outst_q;
    err_d      = err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (issue) begin
      rd_ptr_d              = rd_ptr_q + AW'(1);
      {tx_hdr_d, tx_data_d} = mem_q[rd_ptr_q];
    end

    // A response larger than what is outstanding clamps to 0 and flags the error.
    if (rsp_dec > outst_sum) begin
      outst_d = '0;
      err_d   = 1'b1;
    end else begin
      outst_d = 10'(outst_sum - rsp_dec);
    end
  end

  // Payload write into the FIFO storage.
  always_ff @(posedge pClk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_hdr, req_data};
    end
  end

  // Control and output registers; reset discards all queued and in-flight state.
  always_ff @(posedge pClk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      run_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      tx_valid_q <= 1'b0;
      tx_hdr_q   <= '0;
      tx_data_q  <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      tx_valid_q <= tx_valid_d;
      tx_hdr_q   <= tx_hdr_d;
      tx_data_q  <= tx_data_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_hdr      = tx_hdr_q;
  assign tx_data     = tx_data_q;
  assign fifo_level  = level_q;
  assign outst_cnt   = outst_q;
  assign err_rsp_unf = err_q;

endmodule
